// File: rtl/difficulty_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the difficulty selector: one-hot difficulty codes,
// the selection FSM state type and a priority helper for simultaneous presses.
package difficulty_ctrl_pkg;

    // One-hot difficulty encodings shown on the HEX4 difficulty display.
    localparam logic [2:0] DIFF_EASY = 3'b001;
    localparam logic [2:0] DIFF_MED  = 3'b010;
    localparam logic [2:0] DIFF_HARD = 3'b100;

    // SELECT: keys may change the difficulty. LOCKED: a round is running.
    typedef enum logic {
        SELECT = 1'b0,
        LOCKED = 1'b1
    } ctrl_state_t;

    // Reduce a vector of press events to a single one-hot choice.
    // Lowest bit index wins, so easy beats medium beats hard.
    // With no events the current easy code is returned; callers gate on |ev.
    function automatic logic [2:0] pick_lowest(input logic [2:0] ev);
        logic [2:0] choice;
        choice = DIFF_EASY;
        if (ev[0]) begin
            choice = DIFF_EASY;
        end else if (ev[1]) begin
            choice = DIFF_MED;
        end else if (ev[2]) begin
            choice = DIFF_HARD;
        end
        return choice;
    endfunction

endpackage

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
// One pushbutton channel: 2-flop synchronizer, counter-based debounce and a
// one-cycle press pulse on the debounced released-to-pressed transition.
// A key that is already held when reset ends is ignored until it has been
// seen released for a full debounce window, so held keys never fire on
// their own after reset.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The arming window covers the two synchronizer stages that still hold
    // their reset value right after reset, plus a full debounce window.
    localparam int AW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          armed;
    logic [AW-1:0] arm_cnt;
    logic          flip_to_pressed;

    // The debounced level is about to go low on this cycle.
    assign flip_to_pressed = level && !sync2 && (cnt == CNT_LAST);

    // Two-flop synchronizer; idles at released (1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // samples that differ from the current level; any agreeing sample
    // restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Arming: after reset, require a sustained release before presses count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (!sync2) begin
                arm_cnt <= '0;
            end else if (arm_cnt == ARM_LAST) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    // Registered one-cycle press pulse; releases produce nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press <= 1'b0;
        end else begin
            press <= armed && flip_to_pressed;
        end
    end

endmodule

// File: rtl/difficulty_ctrl.sv
`timescale 1ns/1ps
// Difficulty selector: three debounced keys choose easy/medium/hard while no
// round is running. Outputs the one-hot difficulty, a change pulse and the
// matching round period in milliseconds.
//
// Handshake: there is no valid/ready pair here. diff and period_ms are
// always valid after reset; diff_changed is a single-cycle strobe aligned
// with the first cycle diff shows a new value, and consumers must sample it
// every cycle since it is never held.
module difficulty_ctrl
    import difficulty_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EASY_MS         = 1000,
    parameter int MED_MS          = 600,
    parameter int HARD_MS         = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  key_n,
    input  logic        game_active,
    output logic [2:0]  diff,
    output logic        diff_changed,
    output logic [15:0] period_ms
);

    ctrl_state_t state;
    logic [2:0]  press;
    logic [2:0]  next_diff;
    logic        want_change;

    // Round period for a one-hot difficulty code.
    function automatic logic [15:0] period_of(input logic [2:0] d);
        logic [15:0] p;
        p = 16'(EASY_MS);
        case (d)
            DIFF_EASY: p = 16'(EASY_MS);
            DIFF_MED:  p = 16'(MED_MS);
            DIFF_HARD: p = 16'(HARD_MS);
            default:   p = 16'(EASY_MS);
        endcase
        return p;
    endfunction

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_easy (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n[0]),
        .press (press[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_med (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n[1]),
        .press (press[1])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_hard (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n[2]),
        .press (press[2])
    );

    // Pick the winning press and decide whether it is actually a change.
    always_comb begin
        next_diff   = pick_lowest(press);
        want_change = (|press) && (next_diff != diff);
    end

    // Selection FSM with registered outputs. Presses arriving while locked,
    // or on the cycle the lock engages, are dropped rather than queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SELECT;
            diff         <= DIFF_EASY;
            period_ms    <= 16'(EASY_MS);
            diff_changed <= 1'b0;
        end else begin
            diff_changed <= 1'b0;
            case (state)
                SELECT: begin
                    if (game_active) begin
                        state <= LOCKED;
                    end else if (want_change) begin
                        diff         <= next_diff;
                        period_ms    <= period_of(next_diff);
                        diff_changed <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!game_active) begin
                        state <= SELECT;
                    end
                end
                default: begin
                    state <= SELECT;
                end
            endcase
        end
    end

endmodule

// File: doc/difficulty_ctrl.md
DIFFICULTY_CTRL -- requirements
Module: difficulty_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000; consecutive stable cycles for a key level to be accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter EASY_MS, default 1000; round period for easy.
REQ-003 SHALL have parameter MED_MS, default 600; round period for medium.
REQ-004 SHALL have parameter HARD_MS, default 300; round period for hard.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port key_n  input  3  raw asynchronous pushbuttons, active-low (bit0=KEY[1] easy, bit1=KEY[2] medium, bit2=KEY[3] hard).
REQ-008 SHALL have port game_active  input  1  high while a round runs; locks selection.
REQ-009 SHALL have port diff  output  3  registered one-hot difficulty (001 easy, 010 medium, 100 hard), drives the HEX4 difficulty display.
REQ-010 SHALL have port diff_changed  output  1  one-cycle pulse when diff takes a new value.
REQ-011 SHALL have port period_ms  output  16  registered round period for the current diff.

Function
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each synchronized bit SHALL have a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level; any differing sample clears the counter.
REQ-014 A press event SHALL be a one-cycle debounced released-to-pressed transition; releases generate no event.
REQ-015 The FSM SHALL have two states: SELECT (selection allowed) and LOCKED (selection frozen).
REQ-016 SELECT -> LOCKED SHALL occur on the cycle game_active is sampled high; LOCKED -> SELECT on the cycle it is sampled low.
REQ-017 In SELECT, a press event on key k SHALL set diff to one-hot k on the next rising edge.
REQ-018 Simultaneous press events SHALL resolve with the lowest bit index winning (easy > medium > hard).
REQ-019 Pressing the already-selected key SHALL leave diff unchanged and SHALL NOT pulse diff_changed.
REQ-020 diff_changed SHALL assert for exactly one cycle, coincident with the first cycle diff shows its new value.
REQ-021 In LOCKED, press events SHALL be discarded, not queued; a key held through unlock SHALL not act until released and pressed again.
REQ-022 A press event in the same cycle as a SELECT -> LOCKED transition SHALL be discarded.
REQ-023 period_ms SHALL equal EASY_MS/MED_MS/HARD_MS for diff 001/010/100, registered, updating in the same cycle as diff.
REQ-024 diff SHALL always be exactly one-hot; no input sequence may produce 000 or a multi-hot value.

Reset
REQ-025 While rst_n is sampled low: diff = 001, period_ms = EASY_MS, diff_changed = 0, state = SELECT, synchronizers and debounced levels = released (1), counters = 0.
REQ-026 Reset mid-debounce or mid-lock SHALL abandon the operation; keys held across reset SHALL produce no event until released and re-pressed.

Structure
REQ-027 A shared package SHALL hold the one-hot constants DIFF_EASY/DIFF_MED/DIFF_HARD and the state enum (SELECT, LOCKED).
REQ-028 Synchronizer plus debounce plus edge detect SHALL be the sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated three times.
REQ-029 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, then hold key_n=111 -> diff=001, period_ms=1000, diff_changed never high.
REQ-031 key_n[2] low for 10 cycles in SELECT -> diff=100, period_ms=300, one diff_changed pulse 2+4+1 cycles after the input edge (±1 for synchronizer phase).
REQ-032 key_n[1] bounces 0/1 every 2 cycles for 20 cycles, then released -> no change, no pulse.
REQ-033 key_n=100 (easy and medium) pressed the same cycle from diff=100 -> diff=001, single pulse.
REQ-034 game_active=1, press medium, release, game_active=0 -> diff unchanged, no pulse; a fresh medium press then gives diff=010.
REQ-035 Hold hard through game_active 1->0 and through a rst_n pulse -> diff unchanged after unlock and 001 after reset; no pulse until re-press.
